btn_conditioner: RTL and testbench

- Front-end input stage for the stopwatch/timer display system.
- Takes the raw, bouncy, asynchronous push-button inputs (start, pause, mode, and future buttons).
- For each button, produces a synchronized debounced level, plus single-cycle press, release and long-press pulses.
- Sits directly upstream of the timer core, whose start/pause/mode inputs it drives.

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_conditioner_if.sv | 21 ++
 rtl/btn_channel.sv | 112 +++++++++++
 rtl/btn_conditioner.sv | 39 +++
 tb/tb_btn_conditioner.sv | 135 +++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel state encoding
// and default 100 MHz timing constants.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_10MS = 1000000;
    localparam int LONG_1S       = 100000000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw pins and the timer core: raw inputs in,
// debounced level and event pulses out, one bit per channel.
interface btn_conditioner_if #(parameter int N_BTN = 3);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_long
    );

endinterface

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, debounce FSM, and hold counter
// producing a registered level plus press/release/long-press pulses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int CNT_W           = 27
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic raw,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= RELEASED;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = DB_PRESS;
                    dcnt_d  = '0;
                end
            end
            DB_PRESS: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // Hold time keeps counting on the cycle the release is first seen.
                if (hcnt_q == LONG_LAST) long_d = 1'b1;
                if (hcnt_q != HOLD_MAX)  hcnt_d = hcnt_q + 1'b1;
                if (!sync2_q) begin
                    state_d = DB_RELEASE;
                    dcnt_d  = '0;
                end
            end
            DB_RELEASE: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DB_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end for the stopwatch: N_BTN independent conditioned
// channels feeding the timer core's start/pause/mode inputs.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int CNT_W           = 27
) (
    input logic               clk_100MHz,
    input logic               reset,
    btn_conditioner_if.slave  bus
);

    logic [N_BTN-1:0] level_w, press_w, release_w, long_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .reset      (reset),
            .raw        (bus.btn_raw[i]),
            .level_o    (level_w[i]),
            .press_o    (press_w[i]),
            .release_o  (release_w[i]),
            .long_o     (long_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_long    = long_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_btn_conditioner;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    btn_conditioner_if #(.N_BTN(3)) bus ();

    btn_conditioner #(
        .N_BTN           (3),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .CNT_W           (8)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".level"},   bus.btn_level,   3'b000);
        chk({tag, ".press"},   bus.btn_press,   3'b000);
        chk({tag, ".release"}, bus.btn_release, 3'b000);
        chk({tag, ".long"},    bus.btn_long,    3'b000);
    endtask

    // Steps edges k0..k1 (counted from the raw change) and checks every output.
    // pk/lk/rk: edge after which press/long/release pulse on mask m (0 = never).
    // Level starts at lv0 and flips after edge lvk (0 = never).
    task automatic phase(input string tag, input int k0, input int k1,
                         input logic [2:0] m, input int pk, input int lk,
                         input int rk, input logic lv0, input int lvk);
        for (int k = k0; k <= k1; k++) begin
            logic lv;
            string t;
            step();
            lv = (lvk != 0 && k >= lvk) ? ~lv0 : lv0;
            t  = $sformatf("%s@k%0d", tag, k);
            chk({t, ".level"},   bus.btn_level,   lv       ? m : 3'b000);
            chk({t, ".press"},   bus.btn_press,   (k == pk) ? m : 3'b000);
            chk({t, ".release"}, bus.btn_release, (k == rk) ? m : 3'b000);
            chk({t, ".long"},    bus.btn_long,    (k == lk) ? m : 3'b000);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.btn_raw = 3'b000;
        step();
        step();
        chk_quiet("reset_state");
        reset = 1'b0;
        step();

        // Clean press and release on channel 0
        bus.btn_raw = 3'b001;
        phase("clean_press", 1, 8, 3'b001, 7, 0, 0, 1'b0, 7);
        bus.btn_raw = 3'b000;
        phase("clean_release", 1, 8, 3'b001, 0, 0, 7, 1'b1, 7);

        // Bounce rejection on channel 1
        bus.btn_raw = 3'b010;
        phase("bounce", 1, 1, 3'b010, 0, 0, 0, 1'b0, 0);
        bus.btn_raw = 3'b000;
        phase("bounce", 2, 2, 3'b010, 0, 0, 0, 1'b0, 0);
        bus.btn_raw = 3'b010;
        phase("bounce", 3, 3, 3'b010, 0, 0, 0, 1'b0, 0);
        bus.btn_raw = 3'b000;
        phase("bounce", 4, 12, 3'b010, 0, 0, 0, 1'b0, 0);

        // Long press on channel 2, held 30 cycles
        bus.btn_raw = 3'b100;
        phase("long_hold", 1, 30, 3'b100, 7, 17, 0, 1'b0, 7);
        bus.btn_raw = 3'b000;
        phase("long_release", 1, 8, 3'b100, 0, 0, 7, 1'b1, 7);

        // Release bounce on channel 0: raw low for edges 10-11, hold freezes 2 cycles
        bus.btn_raw = 3'b001;
        phase("rel_bounce", 1, 9, 3'b001, 7, 19, 0, 1'b0, 7);
        bus.btn_raw = 3'b000;
        phase("rel_bounce", 10, 11, 3'b001, 7, 19, 0, 1'b0, 7);
        bus.btn_raw = 3'b001;
        phase("rel_bounce", 12, 22, 3'b001, 7, 19, 0, 1'b0, 7);
        bus.btn_raw = 3'b000;
        phase("rel_bounce_release", 1, 8, 3'b001, 0, 0, 7, 1'b1, 7);

        // Reset while channel 0 is in DB_PRESS
        bus.btn_raw = 3'b001;
        phase("pre_rst_dbp", 1, 4, 3'b001, 7, 0, 0, 1'b0, 7);
        reset = 1'b1;
        step();
        chk_quiet("rst_in_db_press");
        reset = 1'b0;
        phase("after_rst_dbp", 1, 12, 3'b001, 7, 0, 0, 1'b0, 7);

        // Reset while channel 0 is PRESSED with hcnt=5
        reset = 1'b1;
        step();
        chk_quiet("rst_in_pressed");
        reset = 1'b0;
        phase("after_rst_prs", 1, 18, 3'b001, 7, 17, 0, 1'b0, 7);
        bus.btn_raw = 3'b000;
        phase("after_rst_release", 1, 8, 3'b001, 0, 0, 7, 1'b1, 7);

        // Simultaneous press and release on all channels
        bus.btn_raw = 3'b111;
        phase("simul_press", 1, 8, 3'b111, 7, 0, 0, 1'b0, 7);
        bus.btn_raw = 3'b000;
        phase("simul_release", 1, 8, 3'b111, 0, 0, 7, 1'b1, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
